// File: rtl/pdm_sample_feeder.sv
// PCM-to-PDM feeder: small input FIFO, linear interpolation between consecutive samples at PDM rate,
// offset-binary output. Define PDM_FEED_VOLUME_EN to add gain_in scaling (adds one cycle of latency).
module pdm_sample_feeder #(
    parameter int WIDTH      = 16,
    parameter int DIV_LOG2   = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk_in,
    input  logic                            rst_n_in,
    input  logic [WIDTH-1:0]                sample_in,
    input  logic                            sample_valid_in,
    output logic                            sample_ready_out,
    output logic [WIDTH-1:0]                data_out,
    output logic                            tick_out,
    output logic                            underrun_out,
    input  logic                            underrun_clr_in,
`ifdef PDM_FEED_VOLUME_EN
    input  logic [7:0]                      gain_in,
`endif
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level_out
);

    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = WIDTH + 1 + DIV_LOG2;
    localparam logic [LW-1:0]       DEPTH_L   = LW'(FIFO_DEPTH);
    localparam logic [DIV_LOG2-1:0] PHASE_MAX = {DIV_LOG2{1'b1}};
    localparam logic [WIDTH-1:0]    SILENCE   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, STARVED} state_t;

    state_t                     state_reg, state_next;
    logic [DIV_LOG2-1:0]        phase_reg, phase_next;
    logic signed [WIDTH-1:0]    prev_reg, prev_next;
    logic signed [WIDTH-1:0]    target_reg, target_next;
    logic [LW-1:0]              level_reg, level_next;
    logic [AW-1:0]              wr_ptr_reg, rd_ptr_reg;
    logic                       underrun_reg;
    logic [WIDTH-1:0]           data_reg;
    logic [WIDTH-1:0]           mem [FIFO_DEPTH];

    logic                       push, pop, tick, set_underrun;
    logic signed [WIDTH-1:0]    head;
    logic signed [WIDTH-1:0]    interp;
    logic signed [PW-1:0]       prev_ext, target_ext, phase_ext, delta, prod, step, interp_full;
    logic                       unused_bits;

    assign sample_ready_out = (level_reg < DEPTH_L);
    assign push             = sample_valid_in && sample_ready_out;
    assign head             = mem[rd_ptr_reg];
    assign tick             = (phase_reg == PHASE_MAX);
    assign tick_out         = tick;
    assign underrun_out     = underrun_reg;
    assign fifo_level_out   = level_reg;
    assign data_out         = data_reg;

    // FIFO storage carries no reset; pointers and level define validity.
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr_reg] <= sample_in;
        end
    end

    always_comb begin
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + LW'(1);
            2'b01:   level_next = level_reg - LW'(1);
            default: level_next = level_reg;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        prev_next    = prev_reg;
        target_next  = target_reg;
        pop          = 1'b0;
        set_underrun = 1'b0;
        case (state_reg)
            IDLE: begin
                if (level_reg != '0) begin
                    pop         = 1'b1;
                    target_next = head;
                    prev_next   = '0;
                    state_next  = RUN;
                end
            end
            RUN: begin
                if (tick) begin
                    prev_next = target_reg;
                    if (level_reg != '0) begin
                        pop         = 1'b1;
                        target_next = head;
                    end else begin
                        state_next   = STARVED;
                        set_underrun = 1'b1;
                    end
                end
            end
            STARVED: begin
                if (tick && level_reg != '0) begin
                    prev_next   = target_reg;
                    pop         = 1'b1;
                    target_next = head;
                    state_next  = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign phase_next = (state_reg == IDLE) ? '0 : phase_reg + DIV_LOG2'(1);

    // Widened so the full-scale delta times phase cannot overflow; >>> floors negative steps.
    always_comb begin
        prev_ext    = {{(PW-WIDTH){prev_reg[WIDTH-1]}}, prev_reg};
        target_ext  = {{(PW-WIDTH){target_reg[WIDTH-1]}}, target_reg};
        phase_ext   = {{(PW-DIV_LOG2){1'b0}}, phase_reg};
        delta       = target_ext - prev_ext;
        prod        = delta * phase_ext;
        step        = prod >>> DIV_LOG2;
        interp_full = prev_ext + step;
        interp      = interp_full[WIDTH-1:0];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg    <= IDLE;
            phase_reg    <= '0;
            prev_reg     <= '0;
            target_reg   <= '0;
            level_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            underrun_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            phase_reg  <= phase_next;
            prev_reg   <= prev_next;
            target_reg <= target_next;
            level_reg  <= level_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (set_underrun) begin
                underrun_reg <= 1'b1;
            end else if (underrun_clr_in) begin
                underrun_reg <= 1'b0;
            end
        end
    end

`ifdef PDM_FEED_VOLUME_EN
    logic signed [WIDTH+8:0] vol_prod, vol_shift;
    logic signed [WIDTH-1:0] scaled, scaled_reg;

    always_comb begin
        vol_prod  = {{9{interp[WIDTH-1]}}, interp} * {{(WIDTH+1){1'b0}}, gain_in};
        vol_shift = vol_prod >>> 8;
        scaled    = vol_shift[WIDTH-1:0];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            scaled_reg <= '0;
            data_reg   <= SILENCE;
        end else begin
            scaled_reg <= scaled;
            data_reg   <= {~scaled_reg[WIDTH-1], scaled_reg[WIDTH-2:0]};
        end
    end

    assign unused_bits = ^{interp_full[PW-1:WIDTH], vol_shift[WIDTH+8:WIDTH]};
`else
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            data_reg <= SILENCE;
        end else begin
            data_reg <= {~interp[WIDTH-1], interp[WIDTH-2:0]};
        end
    end

    assign unused_bits = ^interp_full[PW-1:WIDTH];
`endif

endmodule

// File: tb/tb_pdm_sample_feeder.sv
// Scoreboard bench for pdm_sample_feeder: a segment-level reference model queues expected outputs per edge,
// a negedge monitor pops and compares. Honours PDM_FEED_VOLUME_EN when defined.
module tb_pdm_sample_feeder;

    localparam int WIDTH      = 16;
    localparam int DIV_LOG2   = 6;
    localparam int FIFO_DEPTH = 4;
    localparam int LW         = $clog2(FIFO_DEPTH + 1);
    localparam int SEG        = 1 << DIV_LOG2;

    logic             clk_in = 1'b0;
    logic             rst_n_in = 1'b0;
    logic [WIDTH-1:0] sample_in = '0;
    logic             sample_valid_in = 1'b0;
    logic             sample_ready_out;
    logic [WIDTH-1:0] data_out;
    logic             tick_out;
    logic             underrun_out;
    logic             underrun_clr_in = 1'b0;
    logic [7:0]       gain_in = 8'd128;
    logic [LW-1:0]    fifo_level_out;

    always #5 clk_in = ~clk_in;

    pdm_sample_feeder #(
        .WIDTH(WIDTH), .DIV_LOG2(DIV_LOG2), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .sample_in(sample_in),
        .sample_valid_in(sample_valid_in),
        .sample_ready_out(sample_ready_out),
        .data_out(data_out),
        .tick_out(tick_out),
        .underrun_out(underrun_out),
        .underrun_clr_in(underrun_clr_in),
`ifdef PDM_FEED_VOLUME_EN
        .gain_in(gain_in),
`endif
        .fifo_level_out(fifo_level_out)
    );

    typedef struct {
        int data;
        int level;
        int ready;
        int tick;
        int uflag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: accepted samples in a queue, plus the segment currently being ramped.
    int m_q[$];
    bit m_started, m_starved, m_uflag;
    int m_prev, m_target, m_phase, m_pend;

    task automatic check(input string name, input logic [31:0] act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int sx16(input int v);
        int w = v & 'hFFFF;
        return (w >= 'h8000) ? w - 'h10000 : w;
    endfunction

    function automatic int offset_bin(input int v);
        return (v + 'h8000) & 'hFFFF;
    endfunction

    function automatic int model_interp();
        longint d = longint'(m_target - m_prev) * longint'(m_phase);
        return m_prev + int'(d >>> DIV_LOG2);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_started = 0;
        m_starved = 0;
        m_uflag   = 0;
        m_prev    = 0;
        m_target  = 0;
        m_phase   = 0;
        m_pend    = 0;
    endtask

    // Called just after a rising edge: drives inputs for the next edge and queues what that edge must produce.
    task automatic drive_cycle(input bit v, input int s, input bit clr, input int g);
        exp_t e;
        int   cur;
        bit   ready_now;
        bit   set_u;
        sample_valid_in = v;
        sample_in       = s[WIDTH-1:0];
        underrun_clr_in = clr;
        gain_in         = g[7:0];

        cur       = model_interp();
        ready_now = (m_q.size() < FIFO_DEPTH);
        set_u     = 0;
`ifdef PDM_FEED_VOLUME_EN
        e.data = offset_bin(m_pend);
        m_pend = (cur * g) >>> 8;
`else
        e.data = offset_bin(cur);
`endif
        if (!m_started) begin
            if (m_q.size() > 0) begin
                m_target  = m_q.pop_front();
                m_prev    = 0;
                m_started = 1;
            end
        end else begin
            if (m_phase == SEG - 1) begin
                m_prev = m_target;
                if (m_q.size() > 0) begin
                    m_target  = m_q.pop_front();
                    m_starved = 0;
                end else if (!m_starved) begin
                    m_starved = 1;
                    set_u     = 1;
                end
            end
            m_phase = (m_phase + 1) % SEG;
        end
        if (set_u) m_uflag = 1;
        else if (clr) m_uflag = 0;
        if (v && ready_now) m_q.push_back(sx16(s));

        e.level = m_q.size();
        e.ready = (m_q.size() < FIFO_DEPTH) ? 1 : 0;
        e.tick  = (m_started && m_phase == SEG - 1) ? 1 : 0;
        e.uflag = m_uflag ? 1 : 0;

        @(posedge clk_in);
        exp_q.push_back(e);
        #1;
    endtask

    always @(negedge clk_in) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("data_out", data_out, e.data);
            check("fifo_level_out", fifo_level_out, e.level);
            check("sample_ready_out", sample_ready_out, e.ready);
            check("tick_out", tick_out, e.tick);
            check("underrun_out", underrun_out, e.uflag);
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_data_out"}, data_out, 'h8000);
        check({tag, "_fifo_level_out"}, fifo_level_out, 0);
        check({tag, "_sample_ready_out"}, sample_ready_out, 1);
        check({tag, "_tick_out"}, tick_out, 0);
        check({tag, "_underrun_out"}, underrun_out, 0);
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++) begin
            int dens = ((i / 100) % 2 == 1) ? 95 : 3;
            int g;
            case ($urandom_range(3))
                0:       g = 0;
                1:       g = 128;
                2:       g = 255;
                default: g = $urandom_range(255);
            endcase
            drive_cycle($urandom_range(99) < dens, int'($urandom), $urandom_range(49) == 0, g);
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk_in);
        #1;
        check_reset_values("reset");

        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;

        // Single sample from idle: ramp from silence, then starve and clear the flag.
        drive_cycle(1, 'h4000, 0, 128);
        repeat (150) drive_cycle(0, 0, 0, 128);
        drive_cycle(0, 0, 1, 128);
        repeat (20) drive_cycle(0, 0, 0, 128);

        // Full-scale swing from +max to -max.
        drive_cycle(1, 'h7FFF, 0, 255);
        drive_cycle(1, 'h8000, 0, 255);
        repeat (200) drive_cycle(0, 0, 0, 255);

        // Alternating sparse / saturating bursts with random values.
        random_run(800);

        // Asynchronous reset between edges, mid-stream.
        @(negedge clk_in);
        #2;
        rst_n_in = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        sample_valid_in = 1'b0;
        underrun_clr_in = 1'b0;
        @(negedge clk_in);
        #2;
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;

        random_run(300);

        @(negedge clk_in);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pdm_sample_feeder.md
Name: pdm_sample_feeder

Overview:
- Sits directly upstream of the PDM modulator.
- Accepts signed PCM samples at audio rate over a valid/ready handshake and buffers them in a small FIFO.
- Linearly interpolates between consecutive samples at the PDM clock rate.
- Emits unsigned offset-binary words sized for the modulator's data input; all logic runs on the PDM clock.

Parameters:
WIDTH, 16, sample and output word width
DIV_LOG2, 6, log2 of PDM clocks per audio sample; segment length 2^DIV_LOG2 (default 64)
FIFO_DEPTH, 4, input FIFO entries, power of two >= 2

Ports:
clk_in  input  1  PDM-rate clock, all logic on rising edge
rst_n_in  input  1  reset, asynchronous, active-low
sample_in  input  WIDTH  signed two's-complement PCM sample
sample_valid_in  input  1  sample_in valid
sample_ready_out  output  1  FIFO can accept; equals (level < FIFO_DEPTH), decoded from registered level
data_out  output  WIDTH  unsigned offset-binary word to PDM modulator, registered
tick_out  output  1  high while phase == 2^DIV_LOG2-1 (segment boundary cycle)
underrun_out  output  1  sticky underrun flag
underrun_clr_in  input  1  clears underrun_out
fifo_level_out  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy

Behaviour:
- Clock/reset: one clock, clk_in; reset rst_n_in is asynchronous, active-low.
- Reset values (asserted immediately, no clock edge needed):
  - data_out = 2^(WIDTH-1), i.e. 0x8000 (silence).
  - FIFO emptied, contents discarded; level 0; sample_ready_out = 1.
  - prev = target = 0; phase = 0; tick_out = 0; underrun_out = 0; state IDLE.
- FIFO:
  - Push on sample_valid_in && sample_ready_out.
  - Pop only at state transitions defined below.
  - Push and pop in the same cycle: level unchanged.
  - When full, ready is 0 and no push occurs; the slot freed by a pop is usable the next cycle.
  - Order is strictly first-in first-out.
- Phase counter: DIV_LOG2-bit.
  - Held at 0 in IDLE.
  - Otherwise increments every cycle and wraps 2^DIV_LOG2-1 -> 0.
- States:
  - IDLE:
    - Phase held at 0.
    - When level > 0: pop into target, prev = 0, go RUN. The ramp starts from silence.
  - RUN, at boundary:
    - prev <= target.
    - If FIFO non-empty: pop into target, stay RUN.
    - Else: target held, go STARVED, set underrun_out.
  - STARVED:
    - prev == target, so output is flat.
    - At each boundary: if FIFO non-empty, prev <= target, pop into target, go RUN; else stay STARVED.
- Interpolation:
  - interp = prev + ((target - prev) * phase) >>> DIV_LOG2.
  - Computed at WIDTH+1+DIV_LOG2 bits signed; arithmetic shift (floor).
  - Result always lies within [prev, target], so no saturation is needed.
- Output:
  - data_out <= interp with MSB inverted (interp + 2^(WIDTH-1) mod 2^WIDTH).
  - Latency: 1 cycle from phase/prev/target to data_out.
- underrun_out:
  - Set on RUN->STARVED.
  - Cleared by underrun_clr_in.
  - Set and clear in the same cycle: set wins.
- Reset mid-operation: all state returns to reset values asynchronously; resumes in IDLE after deassertion.

Optional Feature:
PDM_FEED_VOLUME_EN
- Defined:
  - Adds input gain_in [7:0], unsigned, gain = gain_in/256.
  - scaled = (interp * gain_in) >>> 8, signed, floor.
  - An extra register stage sits before the MSB inversion; data_out latency becomes 2 cycles.
  - gain_in is sampled every cycle; no glitch protection.
- Not defined: no gain_in port; latency 1; data_out derived directly from interp.

Test Plan:
- Reset, no traffic -> data_out=0x8000, sample_ready_out=1, fifo_level_out=0, underrun_out=0, tick_out=0.
- From IDLE, push single 0x4000 (defaults):
  - data_out=0x8000 at phase 0, 0xA000 at phase 32, 0xBF00 at phase 63.
  - Then STARVED: underrun_out=1, data_out holds 0xC000.
  - underrun_clr_in pulse -> underrun_out=0, unless another RUN->STARVED occurs.
- While in RUN, hold sample_valid_in high with distinct values:
  - Level reaches 4, sample_ready_out=0.
  - The next push is accepted only the cycle after a boundary pop.
  - Pop order matches push order.
- prev=0x7FFF, target=0x8000 (-32768) -> data_out=0xFFFF at phase 0, 0x7FFF at phase 32, no wrap/overflow.
- Assert rst_n_in low mid-ramp between clock edges -> data_out=0x8000 and fifo_level_out=0 before the next edge; after release, block is in IDLE.
- PDM_FEED_VOLUME_EN, gain_in=128, steady samples 0x4000 -> data_out settles at 0xA000; gain_in=0 -> 0x8000.
